data_cache: RTL and testbench

- Direct-mapped, write-through, read-allocate data cache.
- Responds to the memory-stage load/store requests of the 5-stage pipeline.
- Refills lines from, and forwards stores to, a word-wide backing memory through a req/ready handshake.
- Raises StallM to the hazard unit while a refill or write-through is outstanding.

---
 rtl/cache_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/data_cache.sv | 157 +++++++++++++++
 tb/tb_data_cache.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the data cache and its lane-alignment helper.
// Combinational content only; no latency.
// Carries no flow control of its own.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int DEF_SETS    = 16;
    localparam int DEF_WPL     = 4;
    localparam int OFFSET_BITS = 2;

    function automatic int word_bits(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int aw, input int sets, input int wpl);
        return aw - OFFSET_BITS - $clog2(sets) - $clog2(wpl);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend, store strobes and lane-replicated store data.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module mem_lane_align
    import cache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] load_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            LB:      load_data = {{24{lane_b[7]}}, lane_b};
            LH:      load_data = {{16{lane_h[15]}}, lane_h};
            LW:      load_data = word;
            LBU:     load_data = {24'b0, lane_b};
            LHU:     load_data = {16'b0, lane_h};
            default: load_data = word;
        endcase

        // misaligned halves/words are forced onto their natural lanes
        case (funct3)
            SB: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{word[7:0]}};
            end
            SH: begin
                wstrb = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{word[15:0]}};
            end
            SW: begin
                wstrb = 4'b1111;
                wdata = word;
            end
            default: begin
                wstrb = 4'b1111;
                wdata = word;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through read-allocate data cache for the memory stage.
// Load hits return in the same cycle; misses refill a line word by word; stores write through.
// Holds StallM while a backing-memory transfer waits on mem_ready; request is held stable.
module data_cache
    import cache_pkg::*;
#(
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WPL,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [31:0]           WriteDataM,
    input  logic [2:0]            AddressingControlM,
    output logic [31:0]           RDM,
    output logic                  StallM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    localparam int WB    = word_bits(WORDS_PER_LINE);
    localparam int IB    = index_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);
    localparam int SET_LO = OFFSET_BITS + WB;
    localparam int TAG_LO = SET_LO + IB;
    localparam logic [WB-1:0] LAST = WB'(WORDS_PER_LINE - 1);

    state_t state, state_nxt;

    logic [WB-1:0]    cnt;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      lines [SETS][WORDS_PER_LINE];

    logic [ADDR_WIDTH-3:0] req_waddr;
    logic [3:0]            req_wstrb;
    logic [31:0]           req_wdata;

    logic [IB-1:0]    in_set, req_set;
    logic [WB-1:0]    in_word, req_word;
    logic [TAG_W-1:0] in_tag, req_tag;
    logic             in_hit, req_hit;

    logic [31:0] al_word, al_load;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;

    assign in_set   = ALUResultM[TAG_LO-1:SET_LO];
    assign in_word  = ALUResultM[SET_LO-1:OFFSET_BITS];
    assign in_tag   = ALUResultM[ADDR_WIDTH-1:TAG_LO];
    assign in_hit   = valid[in_set] && (tags[in_set] == in_tag);

    assign req_set  = req_waddr[WB+IB-1:WB];
    assign req_word = req_waddr[WB-1:0];
    assign req_tag  = req_waddr[ADDR_WIDTH-3:WB+IB];
    assign req_hit  = valid[req_set] && (tags[req_set] == req_tag);

    // one aligner serves both directions: stores win in IDLE, so no load is pending then
    assign al_word = MemWriteM ? WriteDataM : lines[in_set][in_word];

    mem_lane_align u_align (
        .funct3    (AddressingControlM),
        .offset    (ALUResultM[1:0]),
        .word      (al_word),
        .load_data (al_load),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (MemWriteM)                 state_nxt = WRITE;
                else if (MemReadM && !in_hit)  state_nxt = REFILL;
            end
            REFILL: if (mem_ready && cnt == LAST) state_nxt = IDLE;
            WRITE:  if (mem_ready)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        StallM   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        if (!rst) begin
            case (state)
                IDLE: StallM = MemWriteM | (MemReadM & ~in_hit);
                REFILL: begin
                    StallM   = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {req_waddr[ADDR_WIDTH-3:WB], cnt, 2'b00};
                end
                WRITE: begin
                    StallM   = ~mem_ready;
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {req_waddr, 2'b00};
                end
                default: ;
            endcase
        end
        RDM = (!rst && state == IDLE && MemReadM && !MemWriteM && in_hit) ? al_load : 32'b0;
    end

    assign mem_wdata = req_wdata;
    assign mem_wstrb = req_wstrb;

    // the old tag is invalidated on the first beat so a half-written line never hits
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            valid <= '0;
        end else if (state == REFILL && mem_ready) begin
            cnt            <= (cnt == LAST) ? '0 : cnt + 1'b1;
            valid[req_set] <= (cnt == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && (MemReadM || MemWriteM)) begin
            req_waddr <= ALUResultM[ADDR_WIDTH-1:2];
            req_wstrb <= al_wstrb;
            req_wdata <= al_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_ready) begin
            if (state == REFILL) begin
                lines[req_set][cnt] <= mem_rdata;
                if (cnt == LAST) tags[req_set] <= req_tag;
            end
            if (state == WRITE && req_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_wstrb[b]) lines[req_set][req_word][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench: expected memory transfers and load results are queued, a monitor compares.
// Backing memory model with a programmable number of wait cycles per transfer.
`timescale 1ns/1ps
module tb_data_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  AddressingControlM;
    logic [31:0] RDM;
    logic        StallM;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    data_cache #(.SETS(16), .WORDS_PER_LINE(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .AddressingControlM(AddressingControlM),
        .RDM(RDM), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] ld_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          mem_seen = 0;
    int          stall_beats = 0;
    int          wait_cnt = 0;
    logic [31:0] mem [0:1023];

    assign mem_ready = mem_req && (wait_cnt == stall_beats);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ready) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | (i << 2);
        mem[32'h100 >> 2] = 32'hA0;
        mem[32'h104 >> 2] = 32'hA1;
        mem[32'h108 >> 2] = 32'hA2;
        mem[32'h10C >> 2] = 32'hA3;
        forever begin
            @(posedge clk);
            if (mem_req && mem_ready && mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [31:0] a);
        mem_q.push_back('{we: 1'b0, addr: a, wdata: 32'b0, strb: 4'b0});
    endtask

    task automatic exp_line(input logic [31:0] base);
        for (int w = 0; w < 4; w++) exp_rd(base + 32'(4 * w));
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_q.push_back('{we: 1'b1, addr: a, wdata: d, strb: s});
    endtask

    // monitor: memory transfers, request stability under backpressure, load results
    initial begin
        logic        prev_wait = 1'b0;
        logic [31:0] prev_addr = '0;
        logic        prev_we = 1'b0;
        mem_txn_t    e;
        forever begin
            @(negedge clk);
            if (prev_wait && !rst) begin
                chk("mem_req held", {31'b0, mem_req}, 32'd1);
                chk("mem_addr held", mem_addr, prev_addr);
                chk("mem_we held", {31'b0, mem_we}, {31'b0, prev_we});
            end
            prev_wait = mem_req && !mem_ready;
            prev_addr = mem_addr;
            prev_we   = mem_we;
            if (mem_req && mem_ready) begin
                mem_seen++;
                if (mem_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected mem access: got addr %08h we %0d, required none", mem_addr, mem_we);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) begin
                        chk("mem_wdata", mem_wdata, e.wdata);
                        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e.strb});
                    end
                end
            end
            if (MemReadM && !MemWriteM && !StallM && !rst) begin
                if (ld_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected load result: got %08h, required none", RDM);
                end else begin
                    chk($sformatf("RDM @%08h", ALUResultM), RDM, ld_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] exp_rd_val, input int exp_stall);
        int   stalls;
        logic fin;
        if (!wr) ld_q.push_back(exp_rd_val);
        @(posedge clk); #1;
        MemReadM = !wr; MemWriteM = wr; ALUResultM = addr;
        AddressingControlM = f3; WriteDataM = wd;
        stalls = 0;
        fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (StallM) stalls++;
            else begin
                fin = 1'b1;
                if (wr) chk("store stall drops at completion", {31'b0, mem_req & mem_ready}, 32'd1);
                else if (exp_stall == 0) chk("hit issues no mem_req", {31'b0, mem_req}, 32'd0);
            end
            @(posedge clk);
        end
        #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        chk($sformatf("op done @%08h", addr), {31'b0, fin}, 32'd1);
        chk($sformatf("stall cycles @%08h", addr), 32'(stalls), 32'(exp_stall));
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h100;
        AddressingControlM = LW; WriteDataM = 32'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset StallM", {31'b0, StallM}, 32'd0);
        chk("reset mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset RDM", RDM, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;

        // cold miss, then hit in the same line
        exp_line(32'h100);
        do_op(1'b0, 32'h100, LW, 32'h0, 32'h000000A0, 5);
        do_op(1'b0, 32'h108, LW, 32'h0, 32'h000000A2, 0);

        // store hits with merge, then every load flavour
        exp_wr(32'h104, 32'h11223344, 4'b1111);
        do_op(1'b1, 32'h104, SW, 32'h11223344, 32'h0, 1);
        exp_wr(32'h104, 32'hFFFFFFFF, 4'b0010);
        do_op(1'b1, 32'h105, SB, 32'hABCDEFFF, 32'h0, 1);
        do_op(1'b0, 32'h105, LBU,    32'h0, 32'h000000FF, 0);
        do_op(1'b0, 32'h105, LB,     32'h0, 32'hFFFFFFFF, 0);
        do_op(1'b0, 32'h104, LW,     32'h0, 32'h1122FF44, 0);
        do_op(1'b0, 32'h107, LW,     32'h0, 32'h1122FF44, 0);
        do_op(1'b0, 32'h106, LH,     32'h0, 32'h00001122, 0);
        do_op(1'b0, 32'h104, LH,     32'h0, 32'hFFFFFF44, 0);
        do_op(1'b0, 32'h104, LHU,    32'h0, 32'h0000FF44, 0);
        do_op(1'b0, 32'h107, LH,     32'h0, 32'h00001122, 0);
        do_op(1'b0, 32'h105, 3'b011, 32'h0, 32'h1122FF44, 0);
        exp_wr(32'h108, 32'hBEEFBEEF, 4'b1100);
        do_op(1'b1, 32'h10A, SH, 32'h1234BEEF, 32'h0, 1);
        do_op(1'b0, 32'h108, LW, 32'h0, 32'hBEEF00A2, 0);

        // backpressured refill into the same set evicts line 0x100
        stall_beats = 3;
        exp_line(32'h200);
        do_op(1'b0, 32'h200, LW, 32'h0, 32'hC0DE0200, 17);
        do_op(1'b0, 32'h20C, LW, 32'h0, 32'hC0DE020C, 0);
        stall_beats = 0;
        exp_line(32'h100);
        do_op(1'b0, 32'h104, LW, 32'h0, 32'h1122FF44, 5);
        do_op(1'b0, 32'h108, LW, 32'h0, 32'hBEEF00A2, 0);

        // store under backpressure
        stall_beats = 2;
        exp_wr(32'h10C, 32'h12345678, 4'b1111);
        do_op(1'b1, 32'h10C, SW, 32'h12345678, 32'h0, 3);
        do_op(1'b0, 32'h10C, LW, 32'h0, 32'h12345678, 0);
        stall_beats = 0;

        // store miss does not allocate
        pulse_reset();
        exp_wr(32'h400, 32'hDEADBEEF, 4'b1111);
        do_op(1'b1, 32'h400, SW, 32'hDEADBEEF, 32'h0, 1);
        exp_line(32'h400);
        do_op(1'b0, 32'h400, LW, 32'h0, 32'hDEADBEEF, 5);
        do_op(1'b0, 32'h404, LW, 32'h0, 32'hC0DE0404, 0);

        // reset after two of four refill beats
        exp_rd(32'h100);
        exp_rd(32'h104);
        @(posedge clk); #1;
        MemReadM = 1'b1; ALUResultM = 32'h100; AddressingControlM = LW;
        base = mem_seen;
        for (int c = 0; c < 100 && mem_seen < base + 2; c++) @(negedge clk);
        chk("two beats before reset", 32'(mem_seen - base), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1; MemReadM = 1'b0;
        @(negedge clk);
        chk("mid-refill reset mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid-refill reset StallM", {31'b0, StallM}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_line(32'h100);
        do_op(1'b0, 32'h100, LW, 32'h0, 32'h000000A0, 5);
        do_op(1'b0, 32'h10C, LW, 32'h0, 32'h12345678, 0);

        repeat (3) @(posedge clk);
        chk("mem queue drained", 32'(mem_q.size()), 32'd0);
        chk("load queue drained", 32'(ld_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
